// File: rtl/dpram_pkg.sv
// Shared constants and helpers for the dual-port RAM arbiter.
package dpram_pkg;

   localparam int DEF_NREQ  = 2;
   localparam int DEF_WIDTH = 32;
   localparam int DEF_DEPTH = 1024;

   // Ceiling log2, usable in parameter expressions; clog2(1) = 0.
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   localparam int DEF_AW = clog2(DEF_DEPTH);

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the winner is the first request at or after the pointer,
// searching upward modulo NREQ; the pointer moves past the winner on each grant.
module rr_arbiter
   import dpram_pkg::*;
#(
   parameter  int NREQ = DEF_NREQ,
   localparam int PW   = (NREQ > 1) ? clog2(NREQ) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic            en,
   output logic [NREQ-1:0] gnt,
   output logic [PW-1:0]   gnt_idx
);

   logic [PW-1:0] r_ptr;
   logic [PW-1:0] w_idx;
   logic          w_any;

   // gnt_idx is the winner even when en is low, so the caller can inspect the
   // candidate (e.g. for a hazard check) before deciding to enable the grant.
   // NOTE: every variable written here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      w_idx = '0;
      w_any = 1'b0;
      for (int o = 0; o < NREQ; o++) begin
         if (!w_any && req[(int'(r_ptr) + o) % NREQ]) begin
            w_any = 1'b1;
            w_idx = PW'((int'(r_ptr) + o) % NREQ);
         end
      end
   end

   always_comb begin
      gnt = '0;
      if (en && w_any) begin
         gnt[w_idx] = 1'b1;
      end
   end

   assign gnt_idx = w_idx;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of process evaluation order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (en && w_any) begin
         r_ptr <= (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + PW'(1);
      end
   end

endmodule

// File: rtl/dpram_arbiter.sv
// Shares one dual-port RAM (write port A, registered read port B) among NREQ
// requesters. Optional macro DPRAM_ARB_FWD_EN forwards same-address write data
// to a same-cycle read instead of stalling the read.
module dpram_arbiter
   import dpram_pkg::*;
#(
   parameter  int NREQ  = DEF_NREQ,
   parameter  int WIDTH = DEF_WIDTH,
   parameter  int DEPTH = DEF_DEPTH,
   localparam int AW    = clog2(DEPTH),
   localparam int PW    = (NREQ > 1) ? clog2(NREQ) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ-1:0]       req_we,
   input  logic [NREQ*AW-1:0]    req_addr,
   input  logic [NREQ*WIDTH-1:0] req_wdata,
   output logic [NREQ-1:0]       rsp_valid,
   output logic [WIDTH-1:0]      rsp_data,
   output logic                  ram_wen,
   output logic [AW-1:0]         ram_addra,
   output logic [WIDTH-1:0]      ram_dina,
   output logic                  ram_ren,
   output logic [AW-1:0]         ram_addrb,
   input  logic [WIDTH-1:0]      ram_doutb
);

   logic [NREQ-1:0]  w_wr_cand;
   logic [NREQ-1:0]  w_rd_cand;
   logic [NREQ-1:0]  w_wr_gnt;
   logic [NREQ-1:0]  w_rd_gnt;
   logic [PW-1:0]    w_wr_idx;
   logic [PW-1:0]    w_rd_idx;
   logic             w_wr_any;
   logic             w_rd_any;
   logic [AW-1:0]    w_wr_addr;
   logic [AW-1:0]    w_rd_addr;
   logic [WIDTH-1:0] w_wr_data;
   logic             w_hazard;
   logic             w_wr_en;
   logic             w_rd_en;

   logic             r_rd_pending;
   logic [PW-1:0]    r_rd_owner;

   assign w_wr_cand = req_valid & req_we;
   assign w_rd_cand = req_valid & ~req_we;
   assign w_wr_any  = |w_wr_cand;
   assign w_rd_any  = |w_rd_cand;

   assign w_wr_addr = req_addr[int'(w_wr_idx)*AW +: AW];
   assign w_rd_addr = req_addr[int'(w_rd_idx)*AW +: AW];
   assign w_wr_data = req_wdata[int'(w_wr_idx)*WIDTH +: WIDTH];

   // A write always issues when present, so the hazard only depends on whether
   // the read winner targets the write winner's address.
   assign w_hazard = w_wr_any && w_rd_any && (w_wr_addr == w_rd_addr);
   assign w_wr_en  = !rst;
`ifdef DPRAM_ARB_FWD_EN
   assign w_rd_en  = !rst;
`else
   assign w_rd_en  = !rst && !w_hazard;
`endif

   rr_arbiter #(.NREQ(NREQ)) u_wr_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (w_wr_cand),
      .en      (w_wr_en),
      .gnt     (w_wr_gnt),
      .gnt_idx (w_wr_idx)
   );

   rr_arbiter #(.NREQ(NREQ)) u_rd_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (w_rd_cand),
      .en      (w_rd_en),
      .gnt     (w_rd_gnt),
      .gnt_idx (w_rd_idx)
   );

   assign req_ready = w_wr_gnt | w_rd_gnt;

   assign ram_wen   = |w_wr_gnt;
   assign ram_addra = ram_wen ? w_wr_addr : '0;
   assign ram_dina  = ram_wen ? w_wr_data : '0;

   assign ram_ren   = |w_rd_gnt;
   assign ram_addrb = ram_ren ? w_rd_addr : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_pending <= 1'b0;
         r_rd_owner   <= '0;
      end else begin
         r_rd_pending <= ram_ren;
         r_rd_owner   <= w_rd_idx;
      end
   end

`ifdef DPRAM_ARB_FWD_EN
   logic             r_fwd_hit;
   logic [WIDTH-1:0] r_fwd_data;

   // The RAM returns old data for a same-cycle same-address read, so the
   // write data is kept here and substituted in the response cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fwd_hit  <= 1'b0;
         r_fwd_data <= '0;
      end else begin
         r_fwd_hit  <= ram_ren && ram_wen && (ram_addra == ram_addrb);
         r_fwd_data <= ram_dina;
      end
   end
`endif

   // Gating with rst drops a response whose read was accepted just before reset.
   always_comb begin
      rsp_valid = '0;
      rsp_data  = '0;
      if (r_rd_pending && !rst) begin
         rsp_valid[r_rd_owner] = 1'b1;
`ifdef DPRAM_ARB_FWD_EN
         rsp_data = r_fwd_hit ? r_fwd_data : ram_doutb;
`else
         rsp_data = ram_doutb;
`endif
      end
   end

endmodule

// File: tb/tb_dpram_arbiter.sv
// Directed self-checking bench for dpram_arbiter with a behavioural RAM model.
module tb_dpram_arbiter;
   import dpram_pkg::*;

   localparam int NREQ  = 2;
   localparam int WIDTH = 32;
   localparam int DEPTH = 1024;
   localparam int AW    = clog2(DEPTH);

   logic                  clk;
   logic                  rst;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ-1:0]       req_we;
   logic [NREQ*AW-1:0]    req_addr;
   logic [NREQ*WIDTH-1:0] req_wdata;
   logic [NREQ-1:0]       rsp_valid;
   logic [WIDTH-1:0]      rsp_data;
   logic                  ram_wen;
   logic [AW-1:0]         ram_addra;
   logic [WIDTH-1:0]      ram_dina;
   logic                  ram_ren;
   logic [AW-1:0]         ram_addrb;
   logic [WIDTH-1:0]      ram_doutb;

   logic [WIDTH-1:0] mem [DEPTH];

   int n_checks;
   int n_errors;

   dpram_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .ram_wen   (ram_wen),
      .ram_addra (ram_addra),
      .ram_dina  (ram_dina),
      .ram_ren   (ram_ren),
      .ram_addrb (ram_addrb),
      .ram_doutb (ram_doutb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Read-first RAM: a same-cycle read of a written address returns old data.
   always_ff @(posedge clk) begin
      if (ram_ren) ram_doutb <= mem[ram_addrb];
      if (ram_wen) mem[ram_addra] <= ram_dina;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic v, input logic we,
                          input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
      req_valid[i]              = v;
      req_we[i]                 = we;
      req_addr[i*AW +: AW]      = a;
      req_wdata[i*WIDTH +: WIDTH] = d;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      set_req(0, 1'b0, 1'b0, '0, '0);
      set_req(1, 1'b0, 1'b0, '0, '0);
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      ram_doutb = '0;
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      mem[10'h001] = 32'h11;
      mem[10'h002] = 32'h22;
      mem[10'h030] = 32'h7;
      mem[10'h040] = 32'h1111;

      // Reset held three cycles with both requesters active.
      rst = 1'b1;
      set_req(0, 1'b1, 1'b0, 10'h001, '0);
      set_req(1, 1'b1, 1'b1, 10'h002, 32'h99);
      tick(); tick(); tick();
      #1;
      check("rst_ready", 64'(req_ready), 64'h0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
      check("rst_wen", 64'(ram_wen), 64'h0);
      check("rst_ren", 64'(ram_ren), 64'h0);

      tick();
      rst = 1'b0;
      idle_all();
      #1;
      check("idle_rsp_valid", 64'(rsp_valid), 64'h0);
      check("idle_rsp_data", 64'(rsp_data), 64'h0);
      check("idle_addra", 64'(ram_addra), 64'h0);

      // Round-robin reads: rd_ptr starts at 0, grants alternate 0,1,0,1.
      set_req(0, 1'b1, 1'b0, 10'h001, '0);
      set_req(1, 1'b1, 1'b0, 10'h002, '0);
      #1;
      check("rr0_ready", 64'(req_ready), 64'h1);
      check("rr0_addrb", 64'(ram_addrb), 64'h001);
      tick(); #1;
      check("rr1_ready", 64'(req_ready), 64'h2);
      check("rr1_rsp_valid", 64'(rsp_valid), 64'h1);
      check("rr1_rsp_data", 64'(rsp_data), 64'h11);
      tick(); #1;
      check("rr2_ready", 64'(req_ready), 64'h1);
      check("rr2_rsp_valid", 64'(rsp_valid), 64'h2);
      check("rr2_rsp_data", 64'(rsp_data), 64'h22);
      tick(); #1;
      check("rr3_ready", 64'(req_ready), 64'h2);
      check("rr3_rsp_data", 64'(rsp_data), 64'h11);
      tick();
      idle_all();
      #1;
      check("rr4_rsp_valid", 64'(rsp_valid), 64'h2);
      check("rr4_rsp_data", 64'(rsp_data), 64'h22);

      // Writes: wr_ptr starts at 0, so req0 wins first.
      tick();
      set_req(0, 1'b1, 1'b1, 10'h010, 32'hDEADBEEF);
      set_req(1, 1'b1, 1'b1, 10'h011, 32'h33);
      #1;
      check("wr0_ready", 64'(req_ready), 64'h1);
      check("wr0_wen", 64'(ram_wen), 64'h1);
      check("wr0_addra", 64'(ram_addra), 64'h010);
      check("wr0_dina", 64'(ram_dina), 64'hDEADBEEF);
      tick();
      set_req(0, 1'b0, 1'b0, '0, '0);
      #1;
      check("wr1_ready", 64'(req_ready), 64'h2);
      check("wr1_dina", 64'(ram_dina), 64'h33);
      tick();
      set_req(1, 1'b1, 1'b0, 10'h010, '0);
      #1;
      check("rd_after_wr_ready", 64'(req_ready), 64'h2);
      check("rd_after_wr_ren", 64'(ram_ren), 64'h1);
      tick();
      idle_all();
      #1;
      check("rd_after_wr_rsp_valid", 64'(rsp_valid), 64'h2);
      check("rd_after_wr_rsp_data", 64'(rsp_data), 64'hDEADBEEF);

      // Concurrent write and read to different addresses.
      set_req(0, 1'b1, 1'b1, 10'h020, 32'h5);
      set_req(1, 1'b1, 1'b0, 10'h030, '0);
      #1;
      check("conc_ready", 64'(req_ready), 64'h3);
      check("conc_wen_ren", 64'({ram_wen, ram_ren}), 64'h3);
      tick();
      idle_all();
      #1;
      check("conc_rsp_valid", 64'(rsp_valid), 64'h2);
      check("conc_rsp_data", 64'(rsp_data), 64'h7);

      // Same-address hazard: the read must observe the new data.
      tick();
      set_req(0, 1'b1, 1'b1, 10'h040, 32'hA5A5);
      set_req(1, 1'b1, 1'b0, 10'h040, '0);
      #1;
`ifdef DPRAM_ARB_FWD_EN
      check("haz_ready", 64'(req_ready), 64'h3);
      check("haz_ren", 64'(ram_ren), 64'h1);
      tick();
      idle_all();
      #1;
      check("haz_rsp_valid", 64'(rsp_valid), 64'h2);
      check("haz_rsp_data", 64'(rsp_data), 64'hA5A5);
`else
      check("haz_ready", 64'(req_ready), 64'h1);
      check("haz_ren", 64'(ram_ren), 64'h0);
      tick();
      set_req(0, 1'b0, 1'b0, '0, '0);
      #1;
      check("haz_late_ready", 64'(req_ready), 64'h2);
      check("haz_late_ren", 64'(ram_ren), 64'h1);
      check("haz_no_early_rsp", 64'(rsp_valid), 64'h0);
      tick();
      idle_all();
      #1;
      check("haz_rsp_valid", 64'(rsp_valid), 64'h2);
      check("haz_rsp_data", 64'(rsp_data), 64'hA5A5);
`endif

      // Reset right after a read transfer drops the response.
      tick();
      set_req(0, 1'b1, 1'b0, 10'h001, '0);
      #1;
      check("rstmid_ready", 64'(req_ready), 64'h1);
      tick();
      rst = 1'b1;
      idle_all();
      #1;
      check("rstmid_rsp_in_rst", 64'(rsp_valid), 64'h0);
      tick();
      rst = 1'b0;
      #1;
      check("rstmid_rsp_after", 64'(rsp_valid), 64'h0);
      set_req(0, 1'b1, 1'b0, 10'h002, '0);
      #1;
      check("rstmid_next_ready", 64'(req_ready), 64'h1);
      tick();
      idle_all();
      #1;
      check("rstmid_next_rsp_valid", 64'(rsp_valid), 64'h1);
      check("rstmid_next_rsp_data", 64'(rsp_data), 64'h22);

      tick();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/dpram_arbiter.md
Name: dpram_arbiter

Overview:
- Shares one dpram (write port A, registered read port B, read latency 1) between NREQ requesters, e.g. instruction fetch and load/store.
- Write and read requests are arbitrated independently with separate round-robin pointers, so one write and one read can issue in the same cycle.
- Each requester sees a valid/ready request channel and a one-cycle-later read response.
- Same-cycle same-address write/read hazards are resolved: write wins and the read stalls.

Parameters:
- NREQ, 2, number of requesters (2..8).
- WIDTH, 32, data width.
- DEPTH, 1024, RAM words.
- AW, clog2(DEPTH), local address width (derived, not overridable).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  request valid per requester.
- req_ready  output  NREQ  request accepted this cycle (combinational grant).
- req_we  input  NREQ  1 = write, 0 = read.
- req_addr  input  NREQ*AW  flattened; requester i at [i*AW +: AW].
- req_wdata  input  NREQ*WIDTH  flattened write data.
- rsp_valid  output  NREQ  one-hot; read data valid for requester i.
- rsp_data  output  WIDTH  shared read data.
- ram_wen  output  1  to dpram wen.
- ram_addra  output  AW  to dpram addra.
- ram_dina  output  WIDTH  to dpram dina.
- ram_ren  output  1  to dpram ren.
- ram_addrb  output  AW  to dpram addrb.
- ram_doutb  input  WIDTH  from dpram registered read data.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Transfer rule: a transfer occurs when req_valid[i] && req_ready[i]. A requester holds we/addr/wdata stable while valid && !ready. req_ready never depends on req_ready.
- Write candidates are valid && we; read candidates are valid && !we. A requester presents at most one request per cycle.
- Round-robin: wr_ptr and rd_ptr are each log2(NREQ) bits and reset to 0.
  - The winner is the first candidate at or after ptr, searching upward modulo NREQ.
  - On a grant to index k, ptr <= (k+1) mod NREQ.
  - ptr holds when there is no grant.
- Write path (combinational, same cycle): ram_wen = write grant, ram_addra/ram_dina = winner's addr/wdata. A write completes at the transfer; it has no response.
- Read path: ram_ren = read grant, ram_addrb = winner's addr.
  - A 1-cycle pipeline register captures rd_owner (index) and rd_pending.
  - In cycle T+1: rsp_valid[owner] = 1, rsp_data = ram_doutb. Latency from transfer to response is exactly 1 cycle.
  - Back-to-back reads are accepted every cycle (throughput 1).
- Hazard (no feature): if a read winner and a write grant in the same cycle have equal addresses, the read is not granted.
  - ram_ren = 0, that req_ready stays 0, and rd_ptr holds.
  - The write proceeds; the read is granted next cycle and returns the new data.
- When both ports are idle, ram_wen = ram_ren = 0 and addresses/data are don't-care but driven to 0.
- Reset values: req_ready = 0 while rst is high, rsp_valid = 0, rsp_data = 0, ram_wen = ram_ren = 0, pointers = 0, rd_pending = 0.
- Reset mid-operation: an in-flight read response is dropped (rsp_valid stays 0 the cycle after reset).
- rsp_data is 0 when rsp_valid is all zero.

Optional Feature:
- Macro: DPRAM_ARB_FWD_EN.
- Defined: the same-address read is granted together with the write. The write data is captured in a forward register, and in T+1 rsp_data = the forwarded wdata instead of ram_doutb (dpram returns old data). No hazard stall.
- Undefined: the stall behaviour above. Either way, a read always observes a write granted in the same or an earlier cycle.

Decomposition:
- Shared package/header dpram_pkg: clog2 function, default WIDTH/DEPTH/NREQ constants.
- Sub-module rr_arbiter (NREQ): inputs req, en, clk, rst; outputs one-hot gnt and gnt_idx; owns its pointer.
- rr_arbiter is instantiated twice, once for writes and once for reads. The read instance's en is gated by the hazard check (no-FWD build).

Test Plan:
- Reset: hold rst 3 cycles with all req_valid = 1 -> req_ready = 0, rsp_valid = 0, ram_wen = ram_ren = 0; wr_ptr = rd_ptr = 0 after release.
- Write then read: req0 writes 0xDEADBEEF @0x010 in cycle 1; req1 reads @0x010 in cycle 2 -> rsp_valid = 2'b10 in cycle 3, rsp_data = 0xDEADBEEF.
- Round-robin: both requesters read continuously (req0 @0x001 = 0x11, req1 @0x002 = 0x22) -> grants alternate 0,1,0,1 and rsp_data alternates 0x11/0x22 one cycle later.
- Concurrent ports: req0 writes 0x5 @0x020 while req1 reads @0x030 (= 0x7) -> both ready in the same cycle, rsp_data = 0x7 next cycle.
- Hazard: req0 writes 0xA5A5 @0x040 (old 0x1111) while req1 reads @0x040.
  - No FWD: req1 ready 1 cycle late, response 0xA5A5 at T+2.
  - FWD: response 0xA5A5 at T+1.
- Reset mid-read: assert rst the cycle after a read transfer -> no rsp_valid pulse; next read after release responds normally.
